// File: rtl/mc_input_buffer.sv
// rtl/mc_input_buffer.sv - multicast router input-buffer bank: per-port unicast lane plus optional multicast lane
//
// mc_input_buffer_lane: one show-ahead FIFO lane.
//   clk, rst          clock and synchronous active-high reset
//   wr_req, wr_data   write request targeting this lane and its flit
//   rd_req            pop request (ignored while empty)
//   data_out          head entry, 0 while empty
//   valid_out, full, afull, count  occupancy state
//   drop              write request refused this cycle (full, no pop)
//
// mc_input_buffer: NPORTS input ports, each steered by flit bit 0 into a
// unicast lane or, where MCAST_MASK enables it, a multicast lane.
//   fifo_clk, rst     clock and synchronous active-high reset
//   data_in/valid_in  incoming flit per port
//   ready_u/ready_m   pop requests per lane
//   data_out_*, valid_out_*, full_*, afull_*, count_*  lane state per port
//   ovf_err           sticky per-port dropped-flit flag

module mc_input_buffer_lane #(
    parameter int DEPTH       = 4,
    parameter int DATASIZE    = 30,
    parameter int AFULL_LEVEL = 3,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_req,
    input  logic [DATASIZE-1:0] wr_data,
    input  logic                rd_req,
    output logic [DATASIZE-1:0] data_out,
    output logic                valid_out,
    output logic                full,
    output logic                afull,
    output logic [CW-1:0]       count,
    output logic                drop
);
    localparam int PW = $clog2(DEPTH);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [PW-1:0]       wp;
    logic [PW-1:0]       rp;
    logic [CW-1:0]       cnt;
    logic                pop;
    logic                accept;

    assign valid_out = (cnt != '0);
    assign full      = (cnt == CW'(DEPTH));
    assign afull     = (cnt >= CW'(AFULL_LEVEL));
    assign count     = cnt;

    // A pop frees the slot in the same cycle, so a full lane can still take
    // a write (write-through). An empty lane never bypasses write to read.
    assign pop    = rd_req & valid_out;
    assign accept = wr_req & (~full | pop);
    assign drop   = wr_req & full & ~pop;

    assign data_out = valid_out ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (accept) wp <= wp + PW'(1);
            if (pop)    rp <= rp + PW'(1);
            cnt <= cnt + CW'(accept) - CW'(pop);
        end
    end

    // Storage is deliberately left out of reset; only the pointers matter.
    always_ff @(posedge clk) begin
        if (!rst && accept) mem[wp] <= wr_data;
    end
endmodule

module mc_input_buffer #(
    parameter int                NPORTS      = 5,
    parameter int                DEPTH       = 4,
    parameter int                DATASIZE    = 30,
    parameter logic [NPORTS-1:0] MCAST_MASK  = 5'b01001,
    parameter int                AFULL_LEVEL = 3,
    localparam int               CW          = $clog2(DEPTH + 1)
) (
    input  logic                         fifo_clk,
    input  logic                         rst,
    input  logic [NPORTS*DATASIZE-1:0]   data_in,
    input  logic [NPORTS-1:0]            valid_in,
    input  logic [NPORTS-1:0]            ready_u,
    input  logic [NPORTS-1:0]            ready_m,
    output logic [NPORTS*DATASIZE-1:0]   data_out_u,
    output logic [NPORTS-1:0]            valid_out_u,
    output logic [NPORTS-1:0]            full_u,
    output logic [NPORTS-1:0]            afull_u,
    output logic [NPORTS*CW-1:0]         count_u,
    output logic [NPORTS*DATASIZE-1:0]   data_out_m,
    output logic [NPORTS-1:0]            valid_out_m,
    output logic [NPORTS-1:0]            full_m,
    output logic [NPORTS-1:0]            afull_m,
    output logic [NPORTS*CW-1:0]         count_m,
    output logic [NPORTS-1:0]            ovf_err
);
    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        logic [DATASIZE-1:0] flit;
        logic                to_m;
        logic                drop_u;
        logic                drop_m;
        logic                ovf_q;

        assign flit = data_in[i*DATASIZE +: DATASIZE];
        // Multicast-flagged flits fall back to unicast on ports without a multicast lane.
        assign to_m = flit[0] & MCAST_MASK[i];

        mc_input_buffer_lane #(
            .DEPTH(DEPTH), .DATASIZE(DATASIZE), .AFULL_LEVEL(AFULL_LEVEL), .CW(CW)
        ) u_lane_u (
            .clk       (fifo_clk),
            .rst       (rst),
            .wr_req    (valid_in[i] & ~to_m),
            .wr_data   (flit),
            .rd_req    (ready_u[i]),
            .data_out  (data_out_u[i*DATASIZE +: DATASIZE]),
            .valid_out (valid_out_u[i]),
            .full      (full_u[i]),
            .afull     (afull_u[i]),
            .count     (count_u[i*CW +: CW]),
            .drop      (drop_u)
        );

        if (MCAST_MASK[i]) begin : g_m
            mc_input_buffer_lane #(
                .DEPTH(DEPTH), .DATASIZE(DATASIZE), .AFULL_LEVEL(AFULL_LEVEL), .CW(CW)
            ) u_lane_m (
                .clk       (fifo_clk),
                .rst       (rst),
                .wr_req    (valid_in[i] & to_m),
                .wr_data   (flit),
                .rd_req    (ready_m[i]),
                .data_out  (data_out_m[i*DATASIZE +: DATASIZE]),
                .valid_out (valid_out_m[i]),
                .full      (full_m[i]),
                .afull     (afull_m[i]),
                .count     (count_m[i*CW +: CW]),
                .drop      (drop_m)
            );
        end else begin : g_no_m
            logic unused_ready_m;
            assign unused_ready_m                     = ready_m[i];
            assign data_out_m[i*DATASIZE +: DATASIZE] = '0;
            assign valid_out_m[i]                     = 1'b0;
            assign full_m[i]                          = 1'b0;
            assign afull_m[i]                         = 1'b0;
            assign count_m[i*CW +: CW]                = '0;
            assign drop_m                             = 1'b0;
        end

        always_ff @(posedge fifo_clk) begin
            if (rst)                  ovf_q <= 1'b0;
            else if (drop_u | drop_m) ovf_q <= 1'b1;
        end

        assign ovf_err[i] = ovf_q;
    end
endmodule

// File: tb/tb_mc_input_buffer.sv
// tb/tb_mc_input_buffer.sv - self-checking bench for mc_input_buffer against a queue model
module tb_mc_input_buffer;
    localparam int                NP    = 5;
    localparam int                DEPTH = 4;
    localparam int                DS    = 30;
    localparam int                AFL   = 3;
    localparam int                CW    = $clog2(DEPTH + 1);
    localparam logic [NP-1:0]     MASK  = 5'b01001;

    logic                 fifo_clk = 1'b0;
    logic                 rst;
    logic [NP*DS-1:0]     data_in;
    logic [NP-1:0]        valid_in, ready_u, ready_m;
    logic [NP*DS-1:0]     data_out_u, data_out_m;
    logic [NP-1:0]        valid_out_u, full_u, afull_u;
    logic [NP-1:0]        valid_out_m, full_m, afull_m;
    logic [NP*CW-1:0]     count_u, count_m;
    logic [NP-1:0]        ovf_err;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [DS-1:0] q_u [NP][$];
    logic [DS-1:0] q_m [NP][$];
    logic [NP-1:0] ovf_model;

    mc_input_buffer #(
        .NPORTS(NP), .DEPTH(DEPTH), .DATASIZE(DS), .MCAST_MASK(MASK), .AFULL_LEVEL(AFL)
    ) dut (
        .fifo_clk(fifo_clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_u(ready_u), .ready_m(ready_m),
        .data_out_u(data_out_u), .valid_out_u(valid_out_u), .full_u(full_u),
        .afull_u(afull_u), .count_u(count_u),
        .data_out_m(data_out_m), .valid_out_m(valid_out_m), .full_m(full_m),
        .afull_m(afull_m), .count_m(count_m), .ovf_err(ovf_err)
    );

    always #5 fifo_clk = ~fifo_clk;

    task automatic chk(input string name, input int port, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s port %0d: got %0h expected %0h at %0t", name, port, act, exp, $time);
        end
    endtask

    function automatic logic [DS-1:0] du(input int i);
        return data_out_u[i*DS +: DS];
    endfunction
    function automatic logic [DS-1:0] dm(input int i);
        return data_out_m[i*DS +: DS];
    endfunction
    function automatic logic [CW-1:0] cu(input int i);
        return count_u[i*CW +: CW];
    endfunction
    function automatic logic [CW-1:0] cm(input int i);
        return count_m[i*CW +: CW];
    endfunction

    // Reference: each lane is a bounded queue; a pop frees room for a same-cycle write.
    task automatic model_step();
        logic [DS-1:0] d;
        bit tm, pu, pm, wu, wm;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                q_u[i].delete();
                q_m[i].delete();
            end
            ovf_model = '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                d  = data_in[i*DS +: DS];
                tm = d[0] && MASK[i];
                wu = valid_in[i] && !tm;
                wm = valid_in[i] && tm;
                pu = ready_u[i] && (q_u[i].size() > 0);
                pm = MASK[i] && ready_m[i] && (q_m[i].size() > 0);
                if (wu && q_u[i].size() == DEPTH && !pu) ovf_model[i] = 1'b1;
                if (wm && q_m[i].size() == DEPTH && !pm) ovf_model[i] = 1'b1;
                if (pu) void'(q_u[i].pop_front());
                if (pm) void'(q_m[i].pop_front());
                if (wu && q_u[i].size() < DEPTH) q_u[i].push_back(d);
                if (wm && q_m[i].size() < DEPTH) q_m[i].push_back(d);
            end
        end
    endtask

    always @(posedge fifo_clk) model_step();

    always @(negedge fifo_clk) begin
        if (chk_en) begin
            for (int i = 0; i < NP; i++) begin
                int su, sm;
                su = q_u[i].size();
                sm = q_m[i].size();
                chk("m_valid_u", i, 32'(valid_out_u[i]), 32'(su > 0));
                chk("m_data_u",  i, 32'(du(i)), su > 0 ? 32'(q_u[i][0]) : 32'd0);
                chk("m_full_u",  i, 32'(full_u[i]),  32'(su == DEPTH));
                chk("m_afull_u", i, 32'(afull_u[i]), 32'(su >= AFL));
                chk("m_count_u", i, 32'(cu(i)), 32'(su));
                chk("m_valid_m", i, 32'(valid_out_m[i]), 32'(sm > 0));
                chk("m_data_m",  i, 32'(dm(i)), sm > 0 ? 32'(q_m[i][0]) : 32'd0);
                chk("m_full_m",  i, 32'(full_m[i]),  32'(sm == DEPTH));
                chk("m_afull_m", i, 32'(afull_m[i]), 32'(sm >= AFL));
                chk("m_count_m", i, 32'(cm(i)), 32'(sm));
                chk("m_ovf",     i, 32'(ovf_err[i]), 32'(ovf_model[i]));
            end
        end
    end

    task automatic tick();
        @(posedge fifo_clk);
        #1;
    endtask

    task automatic clr();
        data_in  = '0;
        valid_in = '0;
        ready_u  = '0;
        ready_m  = '0;
    endtask

    task automatic put(input int p, input logic [DS-1:0] d);
        data_in[p*DS +: DS] = d;
        valid_in[p] = 1'b1;
    endtask

    initial begin
        logic [DS-1:0] exp_drain [4];
        clr();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        chk("rst_valid_u", 0, 32'(valid_out_u), 32'd0);
        chk("rst_count_u", 0, 32'(count_u == '0), 32'd1);
        chk("rst_data_u",  0, 32'(data_out_u == '0), 32'd1);
        chk("rst_ovf",     0, 32'(ovf_err), 32'd0);

        // Steering on port N
        put(0, 30'h11); tick(); clr();
        put(0, 30'h10); tick(); clr();
        chk("steer_vm",  0, 32'(valid_out_m[0]), 32'd1);
        chk("steer_dm",  0, 32'(dm(0)), 32'h11);
        chk("steer_vu",  0, 32'(valid_out_u[0]), 32'd1);
        chk("steer_du",  0, 32'(du(0)), 32'h10);
        chk("steer_cm",  0, 32'(cm(0)), 32'd1);
        chk("steer_cu",  0, 32'(cu(0)), 32'd1);

        // Multicast flag on a port without a multicast lane
        put(1, 30'h3); tick(); clr();
        chk("nomask_du", 1, 32'(du(1)), 32'h3);
        chk("nomask_cu", 1, 32'(cu(1)), 32'd1);
        chk("nomask_vm", 1, 32'(valid_out_m[1]), 32'd0);
        chk("nomask_cm", 1, 32'(cm(1)), 32'd0);

        // Fill and overflow on port S
        for (int k = 0; k < 4; k++) begin
            put(2, 30'h20 + 30'(k)); tick(); clr();
            if (k == 1) chk("fill_afull2", 2, 32'(afull_u[2]), 32'd0);
            if (k == 2) chk("fill_afull3", 2, 32'(afull_u[2]), 32'd1);
        end
        chk("fill_full",  2, 32'(full_u[2]), 32'd1);
        chk("fill_count", 2, 32'(cu(2)), 32'd4);
        put(2, 30'h24); tick(); clr();
        chk("ovf_set",   2, 32'(ovf_err[2]), 32'd1);
        chk("ovf_count", 2, 32'(cu(2)), 32'd4);
        chk("ovf_head",  2, 32'(du(2)), 32'h20);

        // Write-through on a full lane
        put(2, 30'hAA); ready_u[2] = 1'b1; tick(); clr();
        chk("wt_count", 2, 32'(cu(2)), 32'd4);
        chk("wt_head",  2, 32'(du(2)), 32'h21);
        chk("wt_ovf",   2, 32'(ovf_err[2]), 32'd1);
        exp_drain[0] = 30'h21; exp_drain[1] = 30'h22;
        exp_drain[2] = 30'h23; exp_drain[3] = 30'hAA;
        for (int k = 0; k < 4; k++) begin
            chk("drain_head", 2, 32'(du(2)), 32'(exp_drain[k]));
            ready_u[2] = 1'b1; tick(); clr();
        end
        chk("drain_empty", 2, 32'(valid_out_u[2]), 32'd0);
        chk("drain_data",  2, 32'(du(2)), 32'd0);

        // Pointer wrap at steady occupancy 2 on port W unicast
        put(3, 30'h100); tick(); clr();
        put(3, 30'h102); tick(); clr();
        for (int k = 0; k < 10; k++) begin
            chk("wrap_head", 3, 32'(du(3)), 32'h100 + 32'(2 * k));
            put(3, 30'h104 + 30'(2 * k)); ready_u[3] = 1'b1; tick(); clr();
            chk("wrap_count", 3, 32'(cu(3)), 32'd2);
        end

        // Reset mid-stream on port L holding 3 entries with ovf set
        for (int k = 0; k < 5; k++) begin
            put(4, 30'h200 + 30'(2 * k)); tick(); clr();
        end
        ready_u[4] = 1'b1; tick(); clr();
        chk("pre_rst_count", 4, 32'(cu(4)), 32'd3);
        chk("pre_rst_ovf",   4, 32'(ovf_err[4]), 32'd1);
        rst = 1'b1; put(4, 30'h54); tick(); rst = 1'b0; clr();
        chk("rst_counts_u", 4, 32'(count_u == '0), 32'd1);
        chk("rst_counts_m", 4, 32'(count_m == '0), 32'd1);
        chk("rst_vu",       4, 32'(valid_out_u), 32'd0);
        chk("rst_ovf_clr",  4, 32'(ovf_err), 32'd0);
        tick();
        chk("rst_no_store", 4, 32'(valid_out_u[4]), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            clr();
            rst = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 1) == 1) put(p, DS'($urandom()));
                ready_u[p] = ($urandom_range(0, 2) == 0);
                ready_m[p] = ($urandom_range(0, 2) == 0);
            end
            tick();
        end
        rst = 1'b0;
        clr();
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
